// File: rtl/poly_osc.sv
// poly_osc: polyphonic square-wave oscillator bank with note-tag voice allocation
// ports: clk_i clock, rst_i async active-high reset
//        noteOnStrb_i/noteOffStrb_i one-cycle requests, note_i tag, halfCntPeriod_i clocks per half-period
//        wave_o per-voice square wave, active_o per-voice busy, mix_o registered count of high waves,
//        allBusy_o every voice active, drop_o one-cycle pulse for an unserviced note-on
// define OSC_VOICE_STEAL_EN to steal a voice round-robin instead of dropping when all are busy
module poly_osc #(
    parameter int NUM_VOICES = 4,
    parameter int CNT_W = 16,
    parameter int NOTE_W = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                noteOnStrb_i,
    input  logic                                noteOffStrb_i,
    input  logic [NOTE_W-1:0]                   note_i,
    input  logic [CNT_W-1:0]                    halfCntPeriod_i,
    output logic [NUM_VOICES-1:0]               wave_o,
    output logic [NUM_VOICES-1:0]               active_o,
    output logic [$clog2(NUM_VOICES+1)-1:0]     mix_o,
    output logic                                allBusy_o,
    output logic                                drop_o
);
    localparam int MIX_W = $clog2(NUM_VOICES + 1);

    logic [NUM_VOICES-1:0] act, wav, live, hit, hit_oh, free_oh, sel;
    logic [NOTE_W-1:0] tag [NUM_VOICES];
    logic [CNT_W-1:0] per [NUM_VOICES];
    logic [CNT_W-1:0] cnt [NUM_VOICES];
    logic [MIX_W-1:0] mix_n;
    logic take, drop;

    // live: voices still active once this cycle's note-off is applied, so a
    // same-cycle note-on sees the freed slots
    always_comb begin
        live = '0;
        hit = '0;
        mix_n = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            live[i] = act[i] & ~(noteOffStrb_i && tag[i] == note_i);
            hit[i] = live[i] && tag[i] == note_i;
            mix_n = mix_n + MIX_W'(wav[i] & act[i]);
        end
    end

    // lowest set bit of hit, lowest clear bit of live
    assign hit_oh = hit & (~hit + NUM_VOICES'(1));
    assign free_oh = ~live & (live + NUM_VOICES'(1));
    assign take = noteOnStrb_i && halfCntPeriod_i != '0;

`ifdef OSC_VOICE_STEAL_EN
    localparam int PW = $clog2(NUM_VOICES);
    logic [PW-1:0] ptr;
    assign sel = !take ? '0 : hit != '0 ? hit_oh : free_oh != '0 ? free_oh : NUM_VOICES'(1) << ptr;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)
            ptr <= '0;
        else if (take && hit == '0 && free_oh == '0)
            ptr <= (ptr == PW'(NUM_VOICES - 1)) ? '0 : ptr + PW'(1);
`else
    assign sel = !take ? '0 : hit != '0 ? hit_oh : free_oh;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            act <= '0;
            wav <= '0;
            drop <= 1'b0;
            mix_o <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                tag[i] <= '0;
                per[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            drop <= noteOnStrb_i && sel == '0;
            mix_o <= mix_n;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (sel[i]) begin
                    act[i] <= 1'b1;
                    tag[i] <= note_i;
                    per[i] <= halfCntPeriod_i;
                    cnt[i] <= '0;
                    wav[i] <= 1'b0;
                end else if (!live[i]) begin
                    act[i] <= 1'b0;
                    cnt[i] <= '0;
                    wav[i] <= 1'b0;
                end else if (cnt[i] == per[i] - CNT_W'(1)) begin
                    cnt[i] <= '0;
                    wav[i] <= ~wav[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign wave_o = wav;
    assign active_o = act;
    assign allBusy_o = &act;
    assign drop_o = drop;
endmodule
